// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_pkg                                                         |
// | Brief    : Shared types and constants for the core's pipeline stages.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [1:0] state_occ(input pipe_state_t s);
    case (s)
      PS_ONE:  state_occ = 2'd1;
      PS_FULL: state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sat_counter                                                      |
// | Brief    : Event counter that sticks at all-ones; clear beats increment.    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] c_cnt_max = '1;
  localparam logic [W-1:0] c_one     = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stage_skid                                                  |
// | Brief    : Valid/ready pipeline stage register with optional skid entry,    |
// |            flush-to-bubble and saturating stall/flush counters.             |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID_EN = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              clr_cnt_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  import pipe_pkg::*;

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid;
  logic              w_up_ready;
  logic              w_dn_valid;
  logic              w_up_xfer;
  logic              w_dn_xfer;

  assign w_dn_valid = (r_state != PS_EMPTY);
  assign w_up_xfer  = up_valid_i & w_up_ready;
  assign w_dn_xfer  = w_dn_valid & dn_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    if (flush_i) begin
      w_state_nxt = PS_EMPTY;
      w_main_nxt  = NOP_VAL;
    end else begin
      case (r_state)
        PS_EMPTY: begin
          if (w_up_xfer) begin
            w_state_nxt = PS_ONE;
            w_main_nxt  = up_data_i;
          end
        end
        PS_ONE: begin
          if (w_up_xfer && w_dn_xfer) begin
            w_main_nxt = up_data_i;
          end else if (w_up_xfer) begin
            // Only reachable with the skid entry: new beat parks behind main.
            w_state_nxt = PS_FULL;
          end else if (w_dn_xfer) begin
            w_state_nxt = PS_EMPTY;
            w_main_nxt  = NOP_VAL;
          end
        end
        PS_FULL: begin
          if (w_dn_xfer) begin
            w_state_nxt = PS_ONE;
            w_main_nxt  = w_skid;
          end
        end
        default: begin
          w_state_nxt = PS_EMPTY;
          w_main_nxt  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PS_EMPTY;
      r_main  <= NOP_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              r_up_ready;

      always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
          r_skid     <= NOP_VAL;
          r_up_ready <= 1'b1;
        end else begin
          // Ready is a flop so dn_ready_i never reaches up_ready_o combinationally.
          r_up_ready <= (w_state_nxt != PS_FULL);
          if (flush_i) begin
            r_skid <= NOP_VAL;
          end else if ((r_state == PS_ONE) && w_up_xfer && !w_dn_xfer) begin
            r_skid <= up_data_i;
          end else if ((r_state == PS_FULL) && w_dn_xfer) begin
            r_skid <= NOP_VAL;
          end
        end
      end

      assign w_skid     = r_skid;
      assign w_up_ready = r_up_ready;
    end else begin : g_noskid
      assign w_skid     = NOP_VAL;
      assign w_up_ready = ~w_dn_valid | dn_ready_i;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (clr_cnt_i),
    .inc_i (w_dn_valid & ~dn_ready_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (clr_cnt_i),
    .inc_i (flush_i & w_dn_valid),
    .cnt_o (flush_cnt_o)
  );

  assign up_ready_o = w_up_ready;
  assign dn_valid_o = w_dn_valid;
  assign dn_data_o  = r_main;
  assign occ_o      = state_occ(r_state);

endmodule
`default_nettype wire
